// File: rtl/hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: load-use, ID-branch operand
// and MDU structural hazard detection, MDU occupancy countdown and perf counters.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rsD,
  input  logic [4:0]        rtD,
  input  logic              rs_use_idD,
  input  logic              rt_use_idD,
  input  logic              rs_use_exD,
  input  logic              rt_use_exD,
  input  logic              md_useD,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic [4:0]        writeregE,
  input  logic [1:0]        md_opE,
  input  logic              memtoregM,
  input  logic [4:0]        writeregM,
  input  logic              branch_takenD,
  input  logic              jumpD,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_events
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  logic [CNT_W-1:0]  cnt_r;
  logic [PERF_W-1:0] stall_cycles_r;
  logic [PERF_W-1:0] flush_events_r;
  logic              lw_stall_s;
  logic              br_stall_s;
  logic              md_stall_s;
  logic              md_start_s;
  logic              stall_s;
  logic              flush_d_s;

  // $0 is hardwired, so it never creates a dependency
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src == dst) && (dst != 5'd0);
  endfunction

  // Hazard detection; all controls are forced quiet while reset is held
  always_comb begin
    lw_stall_s = 1'b0;
    br_stall_s = 1'b0;
    md_stall_s = 1'b0;
    md_start_s = 1'b0;
    stall_s    = 1'b0;
    flush_d_s  = 1'b0;
    if (reset) begin
      stall_s   = 1'b0;
      flush_d_s = 1'b0;
    end else begin
      case (md_opE)
        2'b01:   md_start_s = 1'b1;
        2'b10:   md_start_s = 1'b1;
        default: md_start_s = 1'b0;
      endcase
      lw_stall_s = regwriteE && memtoregE &&
                   (((rs_use_idD || rs_use_exD) && reg_match(rsD, writeregE)) ||
                    ((rt_use_idD || rt_use_exD) && reg_match(rtD, writeregE)));
      br_stall_s = (rs_use_idD && reg_match(rsD, writeregE) && regwriteE) ||
                   (rt_use_idD && reg_match(rtD, writeregE) && regwriteE) ||
                   (rs_use_idD && reg_match(rsD, writeregM) && memtoregM) ||
                   (rt_use_idD && reg_match(rtD, writeregM) && memtoregM);
      md_stall_s = md_useD && ((cnt_r != {CNT_W{1'b0}}) || md_start_s);
      stall_s    = lw_stall_s || br_stall_s || md_stall_s;
      flush_d_s  = (branch_takenD || jumpD) && !stall_s;
    end
  end

  assign stallF = stall_s;
  assign stallD = stall_s;
  assign flushE = stall_s;
  assign flushD = flush_d_s;

  // MDU occupancy countdown; an op arriving while busy is ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == {CNT_W{1'b0}}) begin
      case (md_opE)
        2'b01:   cnt_r <= MULT_LOAD;
        2'b10:   cnt_r <= DIV_LOAD;
        default: cnt_r <= {CNT_W{1'b0}};
      endcase
    end else begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign md_busy = !reset && (cnt_r != {CNT_W{1'b0}});

  // Saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_r <= {PERF_W{1'b0}};
    end else if (stall_s && (stall_cycles_r != PERF_MAX)) begin
      stall_cycles_r <= stall_cycles_r + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  // Saturating flush-event counter
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_events_r <= {PERF_W{1'b0}};
    end else if (flush_d_s && (flush_events_r != PERF_MAX)) begin
      flush_events_r <= flush_events_r + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      flush_events_r <= flush_events_r;
    end
  end

  // Counters read as zero for the whole time reset is asserted
  assign stall_cycles = reset ? {PERF_W{1'b0}} : stall_cycles_r;
  assign flush_events = reset ? {PERF_W{1'b0}} : flush_events_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven single-cycle hazard vectors
// plus hand-written multi-cycle sequences (load-use, branch, MDU, reset, jump).
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rsD, rtD, writeregE, writeregM;
  logic        rs_use_idD, rt_use_idD, rs_use_exD, rt_use_exD, md_useD;
  logic        regwriteE, memtoregE, memtoregM, branch_takenD, jumpD;
  logic [1:0]  md_opE;
  logic        stallF, stallD, flushD, flushE, md_busy;
  logic [31:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;
  int exp_sc = 0;
  int exp_fe = 0;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4), .PERF_W(32)) dut (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD),
    .rs_use_idD(rs_use_idD), .rt_use_idD(rt_use_idD),
    .rs_use_exD(rs_use_exD), .rt_use_exD(rt_use_exD), .md_useD(md_useD),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .writeregE(writeregE),
    .md_opE(md_opE), .memtoregM(memtoregM), .writeregM(writeregM),
    .branch_takenD(branch_takenD), .jumpD(jumpD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .md_busy(md_busy), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic       rs_id, rt_id, rs_ex, rt_ex, md_use;
    logic       regw_e, mem_e;
    logic [4:0] wr_e;
    logic       mem_m;
    logic [4:0] wr_m;
    logic       br, jmp;
    logic       exp_stall, exp_flush;
  } vec_t;

  vec_t vecs [14];

  task automatic idle();
    rsD = 5'd0; rtD = 5'd0; rs_use_idD = 1'b0; rt_use_idD = 1'b0;
    rs_use_exD = 1'b0; rt_use_exD = 1'b0; md_useD = 1'b0;
    regwriteE = 1'b0; memtoregE = 1'b0; writeregE = 5'd0; md_opE = 2'b00;
    memtoregM = 1'b0; writeregM = 5'd0; branch_takenD = 1'b0; jumpD = 1'b0;
  endtask

  // Compare one cycle at the falling edge, then advance to just after the next rising edge
  task automatic chk(input string name, input logic es, input logic ef,
                     input logic eb, input logic in_rst);
    int sc_req, fe_req;
    @(negedge clk);
    sc_req = in_rst ? 0 : exp_sc;
    fe_req = in_rst ? 0 : exp_fe;
    checks++;
    if (stallF !== es || stallD !== es || flushE !== es || flushD !== ef ||
        md_busy !== eb || stall_cycles !== 32'(sc_req) || flush_events !== 32'(fe_req)) begin
      errors++;
      $display("FAIL %s: got stallF=%0b stallD=%0b flushE=%0b flushD=%0b busy=%0b sc=%0d fe=%0d, required stall=%0b flushD=%0b busy=%0b sc=%0d fe=%0d",
               name, stallF, stallD, flushE, flushD, md_busy, stall_cycles, flush_events,
               es, ef, eb, sc_req, fe_req);
    end
    if (in_rst) begin
      exp_sc = 0;
      exp_fe = 0;
    end else begin
      exp_sc = exp_sc + (es ? 1 : 0);
      exp_fe = exp_fe + (ef ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  // The stimulus must never issue an MDU op while the unit is busy
  always @(negedge clk) begin
    if (!reset && md_busy && md_opE != 2'b00) begin
      errors++;
      $display("FAIL md_op_while_busy: md_opE=%0b issued while md_busy=1", md_opE);
    end
  end

  initial begin
    //          rs     rt     rsi   rti   rse   rte   mdu   rwE   mE    wE     mM    wM     br    j     stall flush
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    idle();
    reset = 1'b1;
    #1;
    chk("reset_0", 1'b0, 1'b0, 1'b0, 1'b1);
    rs_use_idD = 1'b1; rsD = 5'd4; regwriteE = 1'b1; writeregE = 5'd4; jumpD = 1'b1;
    chk("reset_forced_quiet", 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    idle();

    for (int i = 0; i < 14; i++) begin
      rsD = vecs[i].rs; rtD = vecs[i].rt;
      rs_use_idD = vecs[i].rs_id; rt_use_idD = vecs[i].rt_id;
      rs_use_exD = vecs[i].rs_ex; rt_use_exD = vecs[i].rt_ex;
      md_useD = vecs[i].md_use; regwriteE = vecs[i].regw_e; memtoregE = vecs[i].mem_e;
      writeregE = vecs[i].wr_e; memtoregM = vecs[i].mem_m; writeregM = vecs[i].wr_m;
      branch_takenD = vecs[i].br; jumpD = vecs[i].jmp;
      chk($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_flush, 1'b0, 1'b0);
    end

    // Load-use: one stall cycle, then the load is in M and forwarding covers it
    idle(); reset = 1'b1; chk("rst_a", 1'b0, 1'b0, 1'b0, 1'b1); reset = 1'b0;
    regwriteE = 1'b1; memtoregE = 1'b1; writeregE = 5'd1; rsD = 5'd1; rs_use_exD = 1'b1;
    chk("lw_use_stall", 1'b1, 1'b0, 1'b0, 1'b0);
    regwriteE = 1'b0; memtoregE = 1'b0; writeregE = 5'd0; memtoregM = 1'b1; writeregM = 5'd1;
    chk("lw_use_release", 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("lw_use_count", 1'b0, 1'b0, 1'b0, 1'b0);

    // beq on a load result: stalls with load in E and in M, then redirects
    rs_use_idD = 1'b1; rsD = 5'd2; branch_takenD = 1'b1;
    regwriteE = 1'b1; memtoregE = 1'b1; writeregE = 5'd2;
    chk("beq_stall_E", 1'b1, 1'b0, 1'b0, 1'b0);
    regwriteE = 1'b0; memtoregE = 1'b0; writeregE = 5'd0; memtoregM = 1'b1; writeregM = 5'd2;
    chk("beq_stall_M", 1'b1, 1'b0, 1'b0, 1'b0);
    memtoregM = 1'b0; writeregM = 5'd0;
    chk("beq_flush", 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("beq_count", 1'b0, 1'b0, 1'b0, 1'b0);

    // div with mflo waiting in D: 10 stall cycles, md_busy for the last 9
    md_useD = 1'b1; md_opE = 2'b10;
    chk("div_issue", 1'b1, 1'b0, 1'b0, 1'b0);
    md_opE = 2'b00;
    for (int k = 1; k < 10; k++) chk($sformatf("div_busy%0d", k), 1'b1, 1'b0, 1'b1, 1'b0);
    chk("div_done", 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("div_count", 1'b0, 1'b0, 1'b0, 1'b0);

    // mult then reset on the 3rd busy cycle clears the countdown at once
    md_opE = 2'b01;
    chk("mult_issue", 1'b0, 1'b0, 1'b0, 1'b0);
    md_opE = 2'b00; md_useD = 1'b1;
    chk("mult_busy1", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("mult_busy2", 1'b1, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    chk("mult_busy3_reset", 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    chk("mult_after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // Jump held off by a load-use stall: flushes once, on the first free cycle
    regwriteE = 1'b1; memtoregE = 1'b1; writeregE = 5'd1; rsD = 5'd1; rs_use_exD = 1'b1; jumpD = 1'b1;
    chk("jump_stalled", 1'b1, 1'b0, 1'b0, 1'b0);
    regwriteE = 1'b0; memtoregE = 1'b0; writeregE = 5'd0; memtoregM = 1'b1; writeregM = 5'd1;
    chk("jump_flush", 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("jump_squashed", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jump_count", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
